// File: rtl/rom_pkg.sv
// Shared definitions for the shared sprite ROM and its request arbiter:
// arbitration mode selectors and the minimum-1 address-width helper.
package rom_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Bits needed to index `depth` entries; never less than one bit.
  function automatic int addr_width_for(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter for N requesters. MODE selects round-robin (search
// starts at a pointer that moves past each winner) or fixed priority
// (lowest index wins). The grant is combinational and suppressed in reset.
module rr_arbiter
  import rom_pkg::*;
#(
  parameter int  N     = 3,
  parameter int  MODE  = ARB_RR,
  localparam int IDX_W = addr_width_for(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Pick the first requester, scanning upward from the pointer (RR) or from 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_RR) cand = IDX_W'((int'(ptr_q) + k) % N);
      else                cand = IDX_W'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found && !rst) gnt[gnt_idx] = 1'b1;
  end

  // Next pointer: one past the winner after a handshake, otherwise unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_rom_arb.sv
// Single-port synchronous ROM shared by CHANNELS readers. One request is
// granted per cycle; the word returns on the requester's own response slice
// as a one-cycle rsp_valid pulse, and each slice holds its last word.
// Build option: define SHARED_ROM_OUT_REG_EN to add an output register
// stage (latency 2 instead of 1); arbitration is unchanged.
module shared_rom_arb
  import rom_pkg::*;
#(
  parameter int    WIDTH      = 8,
  parameter int    DEPTH      = 256,
  parameter int    CHANNELS   = 3,
  parameter int    ARB_MODE   = ARB_RR,
  parameter string INIT_FILE  = "",
  localparam int   ADDR_WIDTH = addr_width_for(DEPTH),
  localparam int   IDX_W      = addr_width_for(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            req_valid,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr,
  output logic [CHANNELS-1:0]            req_ready,
  output logic [CHANNELS-1:0]            rsp_valid,
  output logic [CHANNELS*WIDTH-1:0]      rsp_data
);

  logic [WIDTH-1:0]      rom_mem [DEPTH];
  logic [CHANNELS-1:0]   gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]      s1_ch_q, s1_ch_d;
  logic                  s1_oob_q, s1_oob_d;
  logic [WIDTH-1:0]      s1_data;
  logic                  out_valid;
  logic [IDX_W-1:0]      out_ch;
  logic [WIDTH-1:0]      out_data;
  logic [WIDTH-1:0]      hold_q [CHANNELS];
  logic [WIDTH-1:0]      hold_d [CHANNELS];

  rr_arbiter #(
    .N    (CHANNELS),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .adv     (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A grant is only ever given to a valid channel, so any grant is a handshake.
  assign req_ready = gnt;
  assign hs        = |gnt;

  // Route the winning channel's address to the memory.
  always_comb begin
    sel_addr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt_idx == IDX_W'(c)) sel_addr = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Tag travelling with the read: which channel, and whether the address was out of range.
  always_comb begin
    s1_valid_d = hs;
    s1_ch_d    = hs ? gnt_idx : s1_ch_q;
    s1_oob_d   = hs ? (int'(sel_addr) >= DEPTH) : s1_oob_q;
  end

  // Registered memory read, left unreset so it maps onto a RAM output register.
  always_ff @(posedge clk) begin
    if (hs) rd_data_q <= rom_mem[sel_addr];
  end

  // Tag register; clearing it on reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_oob_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_oob_q   <= s1_oob_d;
    end
  end

  // Out-of-range reads return zero rather than whatever the array yields.
  assign s1_data = s1_oob_q ? '0 : rd_data_q;

`ifdef SHARED_ROM_OUT_REG_EN
  logic             s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0] s2_ch_q, s2_ch_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;

  // Extra output stage: carry valid, tag and masked data one more cycle.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_ch_d    = s1_valid_q ? s1_ch_q : s2_ch_q;
    s2_data_d  = s1_valid_q ? s1_data : s2_data_q;
  end

  // Output stage register, cleared together with the read stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_ch_q    <= s2_ch_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ch    = s2_ch_q;
  assign out_data  = s2_data_q;
`else
  assign out_valid = s1_valid_q;
  assign out_ch    = s1_ch_q;
  assign out_data  = s1_data;
`endif

  // Per-channel demux: the pulsed slice shows the new word, others hold.
  // Outputs are forced quiet while rst is high so a pending pulse is dropped.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic hit;
      assign hit                          = out_valid && (out_ch == IDX_W'(gi));
      assign hold_d[gi]                   = hit ? out_data : hold_q[gi];
      assign rsp_valid[gi]                = hit && !rst;
      assign rsp_data[gi*WIDTH +: WIDTH]  = rst ? '0 : hold_d[gi];
    end
  endgenerate

  // Per-channel holding registers for the last delivered word.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst) hold_q[c] <= '0;
      else     hold_q[c] <= hold_d[c];
    end
  end

endmodule

// File: tb/tb_shared_rom_arb.sv
// Bench for shared_rom_arb: one round-robin and one fixed-priority instance
// share the same randomized stimulus and are compared each cycle against a
// queue-based reference model derived from the arbitration and latency rules.
`timescale 1ns/1ps
module tb_shared_rom_arb;
  import rom_pkg::*;

  localparam int W  = 8;
  localparam int D  = 200;
  localparam int C  = 3;
  localparam int AW = 8;
`ifdef SHARED_ROM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   req_valid;
  logic [C*AW-1:0] req_addr;
  logic [C-1:0]   rdy_rr, rv_rr, rdy_fp, rv_fp;
  logic [C*W-1:0] rd_rr, rd_fp;

  always #5 clk = ~clk;

  shared_rom_arb #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy_rr), .rsp_valid(rv_rr), .rsp_data(rd_rr));

  shared_rom_arb #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .ARB_MODE(ARB_FIXED)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy_fp), .rsp_valid(rv_fp), .rsp_data(rd_fp));

  typedef struct {
    int m;
    int due;
    int ch;
    int data;
  } rsp_t;

  logic [W-1:0] img [D];
  rsp_t         pend [$];
  logic [W-1:0] last [2][C];
  int           ptr [2];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference grant: round-robin scans from ptr, fixed priority from 0.
  function automatic int pick(input int m, input logic [C-1:0] v);
    for (int k = 0; k < C; k++) begin
      int c;
      c = (m == 0) ? (ptr[m] + k) % C : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int rom_word(input int a);
    return (a < D) ? int'(img[a]) : 0;
  endfunction

  // Compare all outputs of both instances against the model for this cycle.
  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      int g;
      logic [C-1:0]   er, ev;
      logic [C*W-1:0] ed;
      g  = pick(m, req_valid);
      er = (rst || g < 0) ? '0 : C'(1 << g);
      ev = '0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].m == m && pend[i].due == cyc) begin
          if (!rst) begin
            ev = ev | C'(1 << pend[i].ch);
            last[m][pend[i].ch] = W'(pend[i].data);
          end
          pend.delete(i);
        end
      end
      ed = '0;
      for (int c = 0; c < C; c++) ed[c*W +: W] = rst ? '0 : last[m][c];
      if (m == 0) begin
        check_val("rr_ready", 32'(rdy_rr), 32'(er));
        check_val("rr_rsp_valid", 32'(rv_rr), 32'(ev));
        check_val("rr_rsp_data", 32'(rd_rr), 32'(ed));
      end else begin
        check_val("fp_ready", 32'(rdy_fp), 32'(er));
        check_val("fp_rsp_valid", 32'(rv_fp), 32'(ev));
        check_val("fp_rsp_data", 32'(rd_fp), 32'(ed));
      end
    end
  endtask

  // Advance the model across a rising edge.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        ptr[m] = 0;
        for (int c = 0; c < C; c++) last[m][c] = '0;
      end else begin
        int g;
        g = pick(m, req_valid);
        if (g >= 0) begin
          int a;
          rsp_t r;
          a      = int'(req_addr[g*AW +: AW]);
          r.m    = m;
          r.due  = cyc + 1 + LAT - 1;
          r.ch   = g;
          r.data = rom_word(a);
          r.due  = cyc + LAT;
          pend.push_back(r);
          if (m == 0) ptr[m] = (g + 1) % C;
          $display("cyc=%0d mode=%s grant ch%0d addr=0x%02h data=0x%02h",
                   cyc, (m == 0) ? "rr" : "fp", g, a, r.data);
        end
      end
    end
    if (rst) pend.delete();
    cyc++;
  endtask

  task automatic step(input logic r, input logic [C-1:0] v, input logic [C*AW-1:0] a);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_addr  = a;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [C*AW-1:0] rand_addrs();
    logic [C*AW-1:0] a;
    for (int c = 0; c < C; c++) a[c*AW +: AW] = AW'($urandom_range(0, 255));
    return a;
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    for (int i = 0; i < D; i++) begin
      img[i] = W'($urandom);
      if (i == 5) img[i] = 8'hA7;
      dut_rr.rom_mem[i] = img[i];
      dut_fp.rom_mem[i] = img[i];
    end
    ptr[0] = 0;
    ptr[1] = 0;
    for (int m = 0; m < 2; m++) for (int c = 0; c < C; c++) last[m][c] = '0;

    // Reset state.
    repeat (3) step(1'b1, '0, '0);

    // Single read on ch0 at address 5, then idle to observe the response.
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'h05});
    repeat (3) step(1'b0, '0, '0);

    // All channels valid for six cycles straight after reset.
    step(1'b1, '0, '0);
    repeat (6) step(1'b0, 3'b111, rand_addrs());
    repeat (3) step(1'b0, '0, '0);

    // ch1 and ch2 held valid: fixed priority starves ch2.
    repeat (6) step(1'b0, 3'b110, rand_addrs());
    repeat (3) step(1'b0, '0, '0);

    // Address range boundaries: last valid word, first invalid, 0xF0, top.
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'd199});
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'd200});
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'hF0});
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'hFF});
    repeat (3) step(1'b0, '0, '0);

    // Handshake on ch2, reset the following cycle, then all valid after release.
    step(1'b0, 3'b100, {8'h07, 8'h00, 8'h00});
    step(1'b1, 3'b100, {8'h07, 8'h00, 8'h00});
    step(1'b1, '0, '0);
    repeat (4) step(1'b0, 3'b111, rand_addrs());
    repeat (3) step(1'b0, '0, '0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), C'($urandom_range(0, 7)), rand_addrs());
    end
    repeat (4) step(1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
